// File: rtl/alu_exec_seq_if.sv
// Handshake bundle between decode/issue and the ALU execute unit.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the issue side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid/in_ready          operation handshake
//   opcode/funct3/funct7       instruction fields [6:0], [14:12], [31:25]
//   op_a/op_b                  operands (rs1 or PC, rs2 or immediate)
//   out_valid/out_ready        result handshake
//   result/branch_taken/illegal execution outcome, held while out_valid && !out_ready
interface alu_exec_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            branch_taken;
    logic            illegal;

    // Issuing side (decode stage / testbench).
    modport master (
        output in_valid, opcode, funct3, funct7, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, branch_taken, illegal
    );

    // Execute unit side.
    modport slave (
        input  in_valid, opcode, funct3, funct7, op_a, op_b, out_ready,
        output in_ready, out_valid, result, branch_taken, illegal
    );
endinterface

// File: rtl/alu_exec_seq.sv
// RV32I(+M) ALU: decodes opcode/funct3/funct7 and executes, including an iterative divider.
// Latency: 1 cycle for all ops except non-special DIV/DIVU/REM/REMU, which take XLEN+1 cycles.
// Backpressure: result held until out_ready; in_ready only in IDLE or when DONE is draining.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset; aborts any divide in flight
//   flush    synchronous abort of in-flight op / held result; same-cycle in_valid ignored
//   bus      alu_exec_seq_if.slave: operation in, result out (see interface file)
module alu_exec_seq #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    alu_exec_seq_if.slave bus
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            brt_q, brt_d;
    logic            ill_q, ill_d;
    // Divider: quo_q starts as the dividend magnitude and is shifted out
    // MSB-first while quotient bits are shifted in at the LSB.
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            isrem_q, isrem_d;

    // ------------------------------------------------------------------
    // Datapath primitives on the incoming operands
    // ------------------------------------------------------------------
    logic [XLEN-1:0] a, b;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [SHW-1:0]  shamt;

    assign a     = bus.op_a;
    assign b     = bus.op_b;
    assign f3    = bus.funct3;
    assign f7    = bus.funct7;
    assign shamt = b[SHW-1:0];

    logic [XLEN-1:0] sum_v, diff_v, sll_v, srl_v, sra_v;
    logic            eq_v, lt_s, lt_u;

    assign sum_v  = a + b;
    assign diff_v = a - b;
    assign sll_v  = a << shamt;
    assign srl_v  = a >> shamt;
    assign sra_v  = $signed(a) >>> shamt;
    assign eq_v   = (a == b);
    assign lt_s   = ($signed(a) < $signed(b));
    assign lt_u   = (a < b);

    // SUB/SRA select: OP uses funct7 for both; OP-IMM only for SRAI (ADDI has no SUB form).
    logic alt_sel;
    assign alt_sel = (f7 == F7_ALT) && ((bus.opcode == OPC_OP) || (f3 == 3'b101));

    logic [XLEN-1:0] base_res;
    always_comb begin
        base_res = '0;
        case (f3)
            3'b000:  base_res = alt_sel ? diff_v : sum_v;
            3'b001:  base_res = sll_v;
            3'b010:  base_res = {{(XLEN-1){1'b0}}, lt_s};
            3'b011:  base_res = {{(XLEN-1){1'b0}}, lt_u};
            3'b100:  base_res = a ^ b;
            3'b101:  base_res = alt_sel ? sra_v : srl_v;
            3'b110:  base_res = a | b;
            default: base_res = a & b;
        endcase
    end

    // One shared 2*XLEN multiplier; operand extension picks s*s / s*u / u*u.
    // The low half is identical for all three, so MUL uses it unchanged.
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
    always_comb begin
        mul_a = ((f3 == 3'b001) || (f3 == 3'b010)) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        mul_b = (f3 == 3'b001) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        mul_p = mul_a * mul_b;
    end

    // Divide setup: funct3[0]=0 is signed, funct3[1]=1 selects remainder.
    logic            div_signed, div_rem, a_neg, b_neg, b_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    always_comb begin
        div_signed = ~f3[0];
        div_rem    = f3[1];
        a_neg      = div_signed & a[XLEN-1];
        b_neg      = div_signed & b[XLEN-1];
        a_mag      = a_neg ? (~a + 1'b1) : a;
        b_mag      = b_neg ? (~b + 1'b1) : b;
        b_zero     = (b == '0);
        div_ovf    = div_signed && (a == MIN_V) && (b == '1);
    end

    // ------------------------------------------------------------------
    // Decode: result of a single-cycle op, or a request to start the divider
    // ------------------------------------------------------------------
    logic [XLEN-1:0] dec_res;
    logic            dec_br, dec_ill, dec_div;

    always_comb begin
        dec_res = '0;
        dec_br  = 1'b0;
        dec_ill = 1'b0;
        dec_div = 1'b0;
        case (bus.opcode)
            OPC_LUI: dec_res = b;
            OPC_AUIPC, OPC_JAL, OPC_JALR: dec_res = sum_v;
            OPC_LOAD: begin
                if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)) dec_ill = 1'b1;
                else                                                     dec_res = sum_v;
            end
            OPC_STORE: begin
                if (f3[2] || (f3 == 3'b011)) dec_ill = 1'b1;
                else                         dec_res = sum_v;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  dec_br = eq_v;
                    3'b001:  dec_br = ~eq_v;
                    3'b100:  dec_br = lt_s;
                    3'b101:  dec_br = ~lt_s;
                    3'b110:  dec_br = lt_u;
                    3'b111:  dec_br = ~lt_u;
                    default: dec_ill = 1'b1;
                endcase
                dec_res = {{(XLEN-1){1'b0}}, dec_br};
            end
            OPC_OPIMM: begin
                if ((f3 == 3'b001) && (f7 != F7_BASE))
                    dec_ill = 1'b1;
                else if ((f3 == 3'b101) && (f7 != F7_BASE) && (f7 != F7_ALT))
                    dec_ill = 1'b1;
                else
                    dec_res = base_res;
            end
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    dec_res = base_res;
                end else if ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
                    dec_res = base_res;
                end else if (ENABLE_M && (f7 == F7_M)) begin
                    if (!f3[2])
                        dec_res = (f3 == 3'b000) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
                    else if (b_zero)
                        dec_res = div_rem ? a : '1;
                    else if (div_ovf)
                        dec_res = div_rem ? '0 : MIN_V;
                    else
                        dec_div = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Restoring divide step (one quotient bit per cycle)
    // ------------------------------------------------------------------
    logic [XLEN:0]   trial, trial_sub;
    logic            q_bit;
    logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;

    always_comb begin
        trial     = {rem_q, quo_q[XLEN-1]};
        trial_sub = trial - {1'b0, dvs_q};
        // Partial remainder < 2*divisor, so MSB of the difference is a clean borrow flag.
        q_bit     = ~trial_sub[XLEN];
        rem_nx    = q_bit ? trial_sub[XLEN-1:0] : trial[XLEN-1:0];
        quo_nx    = {quo_q[XLEN-2:0], q_bit};
        q_fix     = qneg_q ? (~quo_nx + 1'b1) : quo_nx;
        r_fix     = rneg_q ? (~rem_nx + 1'b1) : rem_nx;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic accept;
    assign bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready && !flush;

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        brt_d   = brt_q;
        ill_d   = ill_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        isrem_d = isrem_q;

        if (state_q == ST_DIV) begin
            quo_d = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SHW'(XLEN-1)) begin
                state_d = ST_DONE;
                res_d   = isrem_q ? r_fix : q_fix;
            end
        end else if (accept) begin
            brt_d = dec_br;
            ill_d = dec_ill;
            if (dec_div) begin
                state_d = ST_DIV;
                res_d   = '0;
                quo_d   = a_mag;
                rem_d   = '0;
                dvs_d   = b_mag;
                cnt_d   = '0;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                isrem_d = div_rem;
            end else begin
                state_d = ST_DONE;
                res_d   = dec_res;
            end
        end else if ((state_q == ST_DONE) && bus.out_ready) begin
            state_d = ST_IDLE;
            res_d   = '0;
            brt_d   = 1'b0;
            ill_d   = 1'b0;
        end

        if (flush) begin
            state_d = ST_IDLE;
            res_d   = '0;
            brt_d   = 1'b0;
            ill_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            brt_q   <= 1'b0;
            ill_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            isrem_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            brt_q   <= brt_d;
            ill_q   <= ill_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            isrem_q <= isrem_d;
        end
    end

    assign bus.out_valid    = (state_q == ST_DONE);
    assign bus.result       = res_q;
    assign bus.branch_taken = brt_q;
    assign bus.illegal      = ill_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed-vector bench for alu_exec_seq: decode/execute results, divider latency,
// backpressure hold, illegal decode, ENABLE_M=0 build, reset/flush abort.
module tb_alu_exec_seq;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;

    int n_chk    = 0;
    int n_bad    = 0;
    int busy_rdy = 0;

    alu_exec_seq_if #(.XLEN(32)) bus ();
    alu_exec_seq_if #(.XLEN(32)) bus_nm ();

    alu_exec_seq #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    alu_exec_seq #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus_nm)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] F0  = 7'b0000000;
    localparam logic [6:0] FA  = 7'b0100000;
    localparam logic [6:0] FM  = 7'b0000001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready high, return outcome and cycles from accept to out_valid.
    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic br, output logic ill,
                          output int lat);
        int waits;
        @(negedge clk);
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        waits = 0;
        while (!bus.in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) busy_rdy++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.result;
        br  = bus.branch_taken;
        ill = bus.illegal;
    endtask

    task automatic do_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_br, input logic exp_ill,
                         input int exp_lat);
        logic [31:0] res;
        logic        br, ill;
        int          lat;
        run_op(opc, f3, f7, a, b, res, br, ill, lat);
        check({tag, ".res"}, res, exp_res);
        check({tag, ".br"},  {31'b0, br},  {31'b0, exp_br});
        check({tag, ".ill"}, {31'b0, ill}, {31'b0, exp_ill});
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    endtask

    // Start DIVU 100/7 and leave it iterating.
    task automatic start_div();
        @(negedge clk);
        bus.opcode   = OP;
        bus.funct3   = 3'b101;
        bus.funct7   = FM;
        bus.op_a     = 32'd100;
        bus.op_b     = 32'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int ov_seen;

        reset_n          = 1'b0;
        flush            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.opcode       = '0;
        bus.funct3       = '0;
        bus.funct7       = '0;
        bus.op_a         = '0;
        bus.op_b         = '0;
        bus.out_ready    = 1'b1;
        bus_nm.in_valid  = 1'b0;
        bus_nm.opcode    = '0;
        bus_nm.funct3    = '0;
        bus_nm.funct7    = '0;
        bus_nm.op_a      = '0;
        bus_nm.op_b      = '0;
        bus_nm.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst.result", bus.result, 32'd0);
        check("rst.illegal", {31'b0, bus.illegal}, 32'd0);
        check("rst.branch", {31'b0, bus.branch_taken}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst.in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Single-cycle arithmetic / logic
        do_op("add_ovf", OP,  3'b000, F0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1);
        do_op("sub",     OP,  3'b000, FA, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        do_op("sra",     OP,  3'b101, FA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 1);
        do_op("srl_msk", OP,  3'b101, F0, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0, 1);
        do_op("slt",     OP,  3'b010, F0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1);
        do_op("sltu",    OP,  3'b011, F0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1);
        do_op("srai",    OPI, 3'b101, FA, 32'hF000_0000, 32'h0000_0008, 32'hFFF0_0000, 1'b0, 1'b0, 1);
        do_op("lui",     LUI, 3'b000, F0, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1'b0, 1'b0, 1);
        do_op("lw",      LD,  3'b010, F0, 32'h0000_1000, 32'h0000_0004, 32'h0000_1004, 1'b0, 1'b0, 1);

        // Multiply
        do_op("mul",     OP, 3'b000, FM, 32'd6,         32'd7,         32'h0000_002A, 1'b0, 1'b0, 1);
        do_op("mulh",    OP, 3'b001, FM, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1);
        do_op("mulhsu",  OP, 3'b010, FM, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        do_op("mulhu",   OP, 3'b011, FM, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);

        // Divide: iterative and special cases
        busy_rdy = 0;
        do_op("divu",    OP, 3'b101, FM, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 33);
        check("divu.busy_in_ready", 32'(busy_rdy), 32'd0);
        do_op("remu",    OP, 3'b111, FM, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 33);
        do_op("div_neg", OP, 3'b100, FM, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0, 33);
        do_op("rem_neg", OP, 3'b110, FM, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, 33);
        do_op("div_z",   OP, 3'b100, FM, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        do_op("remu_z",  OP, 3'b111, FM, 32'd5,         32'd0,         32'd5,         1'b0, 1'b0, 1);
        do_op("div_ovf", OP, 3'b100, FM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1);
        do_op("rem_ovf", OP, 3'b110, FM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1);

        // Branches
        do_op("beq",     BR, 3'b000, F0, 32'd5,         32'd5,         32'd1,         1'b1, 1'b0, 1);
        do_op("blt",     BR, 3'b100, F0, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b1, 1'b0, 1);
        do_op("bltu",    BR, 3'b110, F0, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b0, 1);

        // Illegal decode
        do_op("ill_opc", 7'b1111111, 3'b000, F0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1);
        do_op("ill_slli", OPI, 3'b001, FA, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1);
        do_op("ill_sllf7", OP, 3'b001, FA, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1);
        do_op("ill_br",  BR, 3'b010, F0, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1);
        do_op("ill_ld",  LD, 3'b011, F0, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1);

        // Backpressure: ADD 3+4 held for 5 cycles, then drain and accept in the same cycle
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.opcode    = OP;
        bus.funct3    = 3'b000;
        bus.funct7    = F0;
        bus.op_a      = 32'd3;
        bus.op_b      = 32'd4;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold.out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("hold.result", bus.result, 32'd7);
            check("hold.in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.funct3    = 3'b100;
        bus.op_a      = 32'd5;
        bus.op_b      = 32'd3;
        bus.in_valid  = 1'b1;
        #1;
        check("drain.in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("b2b.out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("b2b.result", bus.result, 32'd6);
        @(posedge clk);
        #1;
        check("b2b.idle", {31'b0, bus.out_valid}, 32'd0);

        // ENABLE_M=0 build: MUL decodes as illegal
        @(negedge clk);
        bus_nm.opcode   = OP;
        bus_nm.funct3   = 3'b000;
        bus_nm.funct7   = FM;
        bus_nm.op_a     = 32'd6;
        bus_nm.op_b     = 32'd7;
        bus_nm.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_nm.in_valid = 1'b0;
        check("nm_mul.out_valid", {31'b0, bus_nm.out_valid}, 32'd1);
        check("nm_mul.illegal", {31'b0, bus_nm.illegal}, 32'd1);
        check("nm_mul.result", bus_nm.result, 32'd0);

        // Reset during divide iteration 10
        start_div();
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstdiv.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rstdiv.in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rstdiv.result", bus.result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) ov_seen++;
        end
        check("rstdiv.no_stale", 32'(ov_seen), 32'd0);

        // Flush during divide iteration 10, with a same-cycle in_valid
        start_div();
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush        = 1'b1;
        bus.opcode   = OP;
        bus.funct3   = 3'b000;
        bus.funct7   = F0;
        bus.op_a     = 32'd1;
        bus.op_b     = 32'd1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("flsdiv.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("flsdiv.in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("flsidle.out_valid", {31'b0, bus.out_valid}, 32'd0);
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) ov_seen++;
        end
        check("flsdiv.no_stale", 32'(ov_seen), 32'd0);

        // Unit still operational after abort
        do_op("post_add", OP, 3'b000, F0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
